// File: rtl/forward_unit_pkg.sv
// forward_unit_pkg: select codes, stage-entry record and match helper shared by forward_unit and fwd_cmp
package forward_unit_pkg;
  localparam int MAX_AW = 16;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  typedef struct packed {
    logic valid;
    logic [MAX_AW-1:0] rd;
    logic reg_write;
    logic mem_read;
  } stage_t;
  function automatic logic hit(input logic we, input logic [MAX_AW-1:0] rd, input logic [MAX_AW-1:0] rs);
    return we && rd != '0 && rd == rs;
  endfunction
endpackage

// File: rtl/fwd_cmp.sv
// fwd_cmp: operand-select code for one source register; ports ex_we/ex_rd, mem_we/mem_rd (writer stages), rs, sel
module fwd_cmp
  import forward_unit_pkg::*;
(
  input  logic              ex_we,
  input  logic [MAX_AW-1:0] ex_rd,
  input  logic              mem_we,
  input  logic [MAX_AW-1:0] mem_rd,
  input  logic [MAX_AW-1:0] rs,
  output logic [1:0]        sel
);
  // hit() rejects rd==0, so a zero source never matches; nearer stage is tested first
  assign sel = hit(ex_we, ex_rd, rs) ? FWD_EXMEM : hit(mem_we, mem_rd, rs) ? FWD_MEMWB : FWD_RF;
endmodule

// File: rtl/forward_unit.sv
// forward_unit: EX/MEM/WB hazard tracking with registered operand forwarding selects and load-use stall
// ports: clk, rst (async active-low), id_* ID-stage instruction, flush, fwd_a/fwd_b, stall, stall_cnt (only with FWD_STALL_CNT_EN)
module forward_unit
  import forward_unit_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);
  if (REG_AW > MAX_AW || REG_AW < 1 || CNT_W < 1) begin : g_bad_cfg
    $error("forward_unit: unsupported REG_AW/CNT_W");
  end
  stage_t pipe [3];
  logic [MAX_AW-1:0] rs1, rs2;
  logic [1:0] sel_a, sel_b;
  logic load, ex_we, mem_we;
  stage_t id_e;
  assign rs1 = MAX_AW'(id_rs1);
  assign rs2 = MAX_AW'(id_rs2);
  assign id_e = '{valid: 1'b1, rd: MAX_AW'(id_rd), reg_write: id_reg_write, mem_read: id_mem_read};
  assign stall = id_valid && pipe[0].valid && pipe[0].mem_read && pipe[0].rd != '0 &&
                 (pipe[0].rd == rs1 || pipe[0].rd == rs2);
  assign load = id_valid && !stall && !flush;
  assign ex_we = pipe[0].valid && pipe[0].reg_write;
  assign mem_we = pipe[1].valid && pipe[1].reg_write;
  fwd_cmp u_cmp_a (.ex_we(ex_we), .ex_rd(pipe[0].rd), .mem_we(mem_we), .mem_rd(pipe[1].rd), .rs(rs1), .sel(sel_a));
  fwd_cmp u_cmp_b (.ex_we(ex_we), .ex_rd(pipe[0].rd), .mem_we(mem_we), .mem_rd(pipe[1].rd), .rs(rs2), .sel(sel_b));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe[0] <= '0;
      pipe[1] <= '0;
      pipe[2] <= '0;
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
    end else begin
      pipe[0] <= load ? id_e : '0;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
      fwd_a <= load ? sel_a : FWD_RF;
      fwd_b <= load ? sel_b : FWD_RF;
    end
  end
`ifdef FWD_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_forward_unit.sv
// tb_forward_unit: directed scoreboard bench for forward_unit (stall_cnt checked when FWD_STALL_CNT_EN is defined)
module tb_forward_unit;
  logic clk = 1'b1;
  logic rst = 1'b1;
  logic id_valid = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [1:0] fwd_a, fwd_b;
  logic stall;
  logic [15:0] stall_cnt;
  typedef struct {
    int cyc;
    logic [1:0] a;
    logic [1:0] b;
    logic s;
    int cnt;
    string nm;
  } exp_t;
  exp_t sb[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  event smp;
  always #5 clk = ~clk;
  forward_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall)
`ifdef FWD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
`ifndef FWD_STALL_CNT_EN
  assign stall_cnt = '0;
`endif
  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  always begin
    @(negedge clk or smp);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check({e.nm, ".fwd_a"}, int'(fwd_a), int'(e.a));
      check({e.nm, ".fwd_b"}, int'(fwd_b), int'(e.b));
      check({e.nm, ".stall"}, int'(stall), int'(e.s));
`ifdef FWD_STALL_CNT_EN
      if (e.cnt >= 0) check({e.nm, ".stall_cnt"}, int'(stall_cnt), e.cnt);
`endif
    end
  end
  task automatic drive(input logic r, input logic v, input int rs1, input int rs2, input int rd,
                       input logic rw, input logic mr, input logic fl);
    rst = r; id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
    id_reg_write = rw; id_mem_read = mr; flush = fl;
  endtask
  task automatic expect_now(input logic [1:0] a, input logic [1:0] b, input logic s, input int cnt, input string nm);
    exp_t e;
    e.cyc = cyc; e.a = a; e.b = b; e.s = s; e.cnt = cnt; e.nm = nm;
    sb.push_back(e);
  endtask
  task automatic tick;
    @(posedge clk);
    #1 cyc++;
  endtask
  task automatic step(input logic r, input logic v, input int rs1, input int rs2, input int rd,
                      input logic rw, input logic mr, input logic fl,
                      input logic [1:0] a, input logic [1:0] b, input logic s, input int cnt, input string nm);
    drive(r, v, rs1, rs2, rd, rw, mr, fl);
    expect_now(a, b, s, cnt, nm);
    tick();
  endtask
  task automatic nop(input string nm, input logic [1:0] a, input logic [1:0] b, input int cnt);
    step(1, 0, 0, 0, 0, 0, 0, 0, a, b, 0, cnt, nm);
  endtask
  initial begin
    #2;
    step(0, 1, 1, 2, 3, 1, 1, 0, 2'b00, 2'b00, 0, 0, "reset0");
    step(0, 1, 1, 2, 3, 1, 1, 0, 2'b00, 2'b00, 0, 0, "reset1");
    // add r3 ; add r6,r3,r4
    step(1, 1, 1, 2, 3, 1, 0, 0, 2'b00, 2'b00, 0, -1, "t1_id");
    step(1, 1, 3, 4, 6, 1, 0, 0, 2'b00, 2'b00, 0, -1, "t1_ex_prod");
    nop("t1_ex_use", 2'b01, 2'b00, -1);
    nop("t1_drain", 2'b00, 2'b00, -1);
    // add r7 ; nop ; add r9,r8,r7
    step(1, 1, 1, 2, 7, 1, 0, 0, 2'b00, 2'b00, 0, -1, "t2_id");
    nop("t2_ex_prod", 2'b00, 2'b00, -1);
    step(1, 1, 8, 7, 9, 1, 0, 0, 2'b00, 2'b00, 0, -1, "t2_bubble");
    nop("t2_ex_use", 2'b00, 2'b10, -1);
    nop("t2_drain", 2'b00, 2'b00, -1);
    // lw r5 ; add r10,r5,r2 -> one stall cycle then MEM/WB forward
    step(1, 1, 1, 2, 5, 1, 1, 0, 2'b00, 2'b00, 0, 0, "t3_id");
    step(1, 1, 5, 2, 10, 1, 0, 0, 2'b00, 2'b00, 1, 0, "t3_stall");
    step(1, 1, 5, 2, 10, 1, 0, 0, 2'b00, 2'b00, 0, 1, "t3_bubble");
    nop("t3_ex_use", 2'b10, 2'b00, 1);
    nop("t3_drain", 2'b00, 2'b00, 1);
    // add r4 ; add r4 ; sub r11,r4,r2 -> nearest wins
    step(1, 1, 1, 2, 4, 1, 0, 0, 2'b00, 2'b00, 0, -1, "t4_id");
    step(1, 1, 1, 2, 4, 1, 0, 0, 2'b00, 2'b00, 0, -1, "t4_first");
    step(1, 1, 4, 2, 11, 1, 0, 0, 2'b00, 2'b00, 0, -1, "t4_second");
    nop("t4_ex_use", 2'b01, 2'b00, -1);
    nop("t4_drain", 2'b00, 2'b00, -1);
    // lw r0 ; add using r0 twice -> no stall, no forward
    step(1, 1, 1, 2, 0, 1, 1, 0, 2'b00, 2'b00, 0, 1, "t5_id");
    step(1, 1, 0, 0, 14, 1, 0, 0, 2'b00, 2'b00, 0, 1, "t5_no_stall");
    nop("t5_ex_use", 2'b00, 2'b00, 1);
    nop("t5_drain", 2'b00, 2'b00, 1);
    // lw r12 ; add r15,r12 flushed while stalled -> killed, no forward
    step(1, 1, 1, 2, 12, 1, 1, 0, 2'b00, 2'b00, 0, 1, "t6_id");
    step(1, 1, 12, 3, 15, 1, 0, 1, 2'b00, 2'b00, 1, 1, "t6_flush_stall");
    nop("t6_killed", 2'b00, 2'b00, 2);
    nop("t6_drain", 2'b00, 2'b00, 2);
    // lw r13 ; add r16,r13 with reset dropped mid-stall
    step(1, 1, 1, 2, 13, 1, 1, 0, 2'b00, 2'b00, 0, 2, "t7_id");
    drive(1, 1, 13, 2, 16, 1, 0, 0);
    expect_now(2'b00, 2'b00, 1, 2, "t7_stall");
    @(negedge clk);
    #1 rst = 1'b0;
    #1 expect_now(2'b00, 2'b00, 0, 0, "t7_rst_async");
    ->smp;
    tick();
    step(0, 1, 13, 2, 16, 1, 0, 0, 2'b00, 2'b00, 0, 0, "t7_rst_held");
    step(1, 1, 13, 2, 16, 1, 0, 0, 2'b00, 2'b00, 0, 0, "t7_after_rst");
    nop("t7_no_fwd", 2'b00, 2'b00, 0);
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
